// File: rtl/usb_ctrl_pkg.sv
// Shared definitions for the USB control/status poller: register map, FSM states,
// MSD status layout and small decode helpers.
package usb_ctrl_pkg;

  localparam logic [31:0] USB_REG_SOFT_RST     = 32'd0;
  localparam logic [31:0] USB_REG_STATUS       = 32'd4;
  localparam logic [31:0] USB_REG_ACK_TIMEOUT  = 32'd8;
  localparam logic [31:0] USB_REG_ACK_RECEIVED = 32'd12;
  localparam logic [31:0] USB_REG_ACK_BAD      = 32'd16;

  typedef enum logic [2:0] {
    S_RST_ASSERT  = 3'd0,
    S_RST_HOLD    = 3'd1,
    S_RST_RELEASE = 3'd2,
    S_POLL_RD     = 3'd3,
    S_POLL_CLR    = 3'd4,
    S_WAIT        = 3'd5
  } usb_state_e;

  typedef struct packed {
    logic rps_tx_err;
    logic get_max_lun;
    logic msd_reset;
  } usb_msd_status_t;

  function automatic logic is_rst_state(input usb_state_e s);
    return (s == S_RST_ASSERT) || (s == S_RST_HOLD) || (s == S_RST_RELEASE);
  endfunction

  // Sweep order is 4, 8, 12, 16; anything else restarts at the status register.
  function automatic logic [31:0] next_poll_adr(input logic [31:0] a);
    logic [31:0] n;
    case (a)
      USB_REG_STATUS:       n = USB_REG_ACK_TIMEOUT;
      USB_REG_ACK_TIMEOUT:  n = USB_REG_ACK_RECEIVED;
      USB_REG_ACK_RECEIVED: n = USB_REG_ACK_BAD;
      default:              n = USB_REG_STATUS;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/usb_sat_counter.sv
// Event counter that sticks at all-ones; a synchronous clear overrides an increment.
module usb_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_r;

  // Count register with clear priority and saturation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= {W{1'b0}};
    end else if (clr_i) begin
      cnt_r <= {W{1'b0}};
    end else if (inc_i && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o = cnt_r;

endmodule

// File: rtl/usb_wb_status_poller.sv
// Wishbone master that sequences the USB soft reset and sweeps the status registers,
// clearing set flags and turning them into event pulses and saturating counters.
module usb_wb_status_poller
  import usb_ctrl_pkg::*;
#(
  parameter int POLL_INTERVAL = 1024,
  parameter int RST_HOLD      = 16,
  parameter int CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             wbm_cyc,
  output logic             wbm_stb,
  output logic             wbm_we,
  output logic [31:0]      wbm_adr,
  output logic [31:0]      wbm_dat_m2s,
  input  logic [31:0]      wbm_dat_s2m,
  input  logic             wbm_ack,
  output logic [3:0]       wbm_sel,
  input  logic             usb_rst_req_i,
  input  logic             cnt_clr_i,
  output logic             busy_o,
  output logic             evt_valid_o,
  output logic [2:0]       evt_status_o,
  output logic [CNT_W-1:0] timeout_cnt_o,
  output logic [CNT_W-1:0] received_cnt_o,
  output logic [CNT_W-1:0] bad_cnt_o
);

  usb_state_e      state_r;
  logic            cyc_r;
  logic            we_r;
  logic [31:0]     adr_r;
  logic [31:0]     dat_r;
  logic [31:0]     tmr_r;
  logic            pend_r;
  logic            busy_r;
  logic            evt_valid_r;
  usb_msd_status_t evt_status_r;

  logic pend_s;
  logic rd_done_s;
  logic rd_nz_s;
  logic inc_to_s;
  logic inc_rc_s;
  logic inc_bad_s;
  logic evt_s;

  // A request outside the reset states waits for the next transaction boundary.
  assign pend_s    = pend_r | (usb_rst_req_i & ~is_rst_state(state_r));
  assign rd_done_s = (state_r == S_POLL_RD) & cyc_r & wbm_ack;
  assign rd_nz_s   = |wbm_dat_s2m;
  assign evt_s     = rd_done_s & rd_nz_s & (adr_r == USB_REG_STATUS);
  assign inc_to_s  = rd_done_s & rd_nz_s & (adr_r == USB_REG_ACK_TIMEOUT);
  assign inc_rc_s  = rd_done_s & rd_nz_s & (adr_r == USB_REG_ACK_RECEIVED);
  assign inc_bad_s = rd_done_s & rd_nz_s & (adr_r == USB_REG_ACK_BAD);

  // Sequencer: every bus state spends one idle cycle, then holds cyc/stb until ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_RST_ASSERT;
      cyc_r   <= 1'b0;
      we_r    <= 1'b0;
      adr_r   <= 32'd0;
      dat_r   <= 32'd0;
      tmr_r   <= 32'd0;
      pend_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      pend_r <= pend_s;
      case (state_r)
        S_RST_ASSERT: begin
          busy_r <= 1'b1;
          pend_r <= 1'b0;
          if (!cyc_r) begin
            cyc_r <= 1'b1;
            we_r  <= 1'b1;
            adr_r <= USB_REG_SOFT_RST;
            dat_r <= 32'd1;
          end else if (wbm_ack) begin
            cyc_r   <= 1'b0;
            we_r    <= 1'b0;
            dat_r   <= 32'd0;
            tmr_r   <= 32'd0;
            state_r <= S_RST_HOLD;
          end else begin
            cyc_r <= 1'b1;
          end
        end
        S_RST_HOLD: begin
          busy_r <= 1'b1;
          pend_r <= 1'b0;
          if (usb_rst_req_i) begin
            tmr_r <= 32'd0;
          end else if (tmr_r == 32'(RST_HOLD - 1)) begin
            tmr_r   <= 32'd0;
            state_r <= S_RST_RELEASE;
          end else begin
            tmr_r <= tmr_r + 32'd1;
          end
        end
        S_RST_RELEASE: begin
          pend_r <= 1'b0;
          if (!cyc_r) begin
            busy_r <= 1'b1;
            cyc_r  <= 1'b1;
            we_r   <= 1'b1;
            adr_r  <= USB_REG_SOFT_RST;
            dat_r  <= 32'd0;
          end else if (wbm_ack) begin
            busy_r  <= 1'b0;
            cyc_r   <= 1'b0;
            we_r    <= 1'b0;
            adr_r   <= USB_REG_STATUS;
            state_r <= S_POLL_RD;
          end else begin
            busy_r <= 1'b1;
          end
        end
        S_POLL_RD: begin
          if (!cyc_r) begin
            cyc_r <= 1'b1;
            we_r  <= 1'b0;
            dat_r <= 32'd0;
          end else if (wbm_ack) begin
            cyc_r <= 1'b0;
            if (pend_s) begin
              pend_r  <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= S_RST_ASSERT;
            end else if (rd_nz_s) begin
              state_r <= S_POLL_CLR;
            end else if (adr_r == USB_REG_ACK_BAD) begin
              tmr_r   <= 32'd0;
              state_r <= S_WAIT;
            end else begin
              adr_r <= next_poll_adr(adr_r);
            end
          end else begin
            cyc_r <= 1'b1;
          end
        end
        S_POLL_CLR: begin
          if (!cyc_r) begin
            cyc_r <= 1'b1;
            we_r  <= 1'b1;
            dat_r <= 32'd0;
          end else if (wbm_ack) begin
            cyc_r <= 1'b0;
            we_r  <= 1'b0;
            if (pend_s) begin
              pend_r  <= 1'b0;
              busy_r  <= 1'b1;
              state_r <= S_RST_ASSERT;
            end else if (adr_r == USB_REG_ACK_BAD) begin
              tmr_r   <= 32'd0;
              state_r <= S_WAIT;
            end else begin
              adr_r   <= next_poll_adr(adr_r);
              state_r <= S_POLL_RD;
            end
          end else begin
            cyc_r <= 1'b1;
          end
        end
        S_WAIT: begin
          if (pend_s) begin
            pend_r  <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= S_RST_ASSERT;
          end else if (tmr_r == 32'(POLL_INTERVAL - 1)) begin
            adr_r   <= USB_REG_STATUS;
            state_r <= S_POLL_RD;
          end else begin
            tmr_r <= tmr_r + 32'd1;
          end
        end
        default: begin
          cyc_r   <= 1'b0;
          we_r    <= 1'b0;
          state_r <= S_RST_ASSERT;
        end
      endcase
    end
  end

  // MSD status event: pulse for one cycle and hold the flags until the next pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      evt_valid_r  <= 1'b0;
      evt_status_r <= usb_msd_status_t'(3'b000);
    end else begin
      evt_valid_r <= evt_s;
      if (evt_s) begin
        evt_status_r <= usb_msd_status_t'(wbm_dat_s2m[2:0]);
      end else begin
        evt_status_r <= evt_status_r;
      end
    end
  end

  usb_sat_counter #(.W(CNT_W)) u_cnt_timeout (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (cnt_clr_i), .inc_i (inc_to_s), .cnt_o (timeout_cnt_o)
  );
  usb_sat_counter #(.W(CNT_W)) u_cnt_received (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (cnt_clr_i), .inc_i (inc_rc_s), .cnt_o (received_cnt_o)
  );
  usb_sat_counter #(.W(CNT_W)) u_cnt_bad (
    .clk_i (clk_i), .rst_i (rst_i), .clr_i (cnt_clr_i), .inc_i (inc_bad_s), .cnt_o (bad_cnt_o)
  );

  assign wbm_cyc      = cyc_r;
  assign wbm_stb      = cyc_r;
  assign wbm_we       = we_r;
  assign wbm_adr      = adr_r;
  assign wbm_dat_m2s  = dat_r;
  assign wbm_sel      = 4'hF;
  assign busy_o       = busy_r;
  assign evt_valid_o  = evt_valid_r;
  assign evt_status_o = evt_status_r;

endmodule

// File: tb/tb_usb_wb_status_poller.sv
// Bench for usb_wb_status_poller: a flag-holding Wishbone slave, a transaction log and
// a sweep-level reference model of expected bus traffic, events and counters.
module tb_usb_wb_status_poller;

  localparam int PI   = 8;
  localparam int RH   = 4;
  localparam int CW   = 3;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          wbm_cyc, wbm_stb, wbm_we;
  logic [31:0]   wbm_adr, wbm_dat_m2s, wbm_dat_s2m;
  logic          wbm_ack;
  logic [3:0]    wbm_sel;
  logic          usb_rst_req_i = 1'b0;
  logic          cnt_clr_i = 1'b0;
  logic          busy_o, evt_valid_o;
  logic [2:0]    evt_status_o;
  logic [CW-1:0] timeout_cnt_o, received_cnt_o, bad_cnt_o;

  always #5 clk = ~clk;

  usb_wb_status_poller #(.POLL_INTERVAL(PI), .RST_HOLD(RH), .CNT_W(CW)) dut (
    .clk_i (clk), .rst_i (rst_i),
    .wbm_cyc (wbm_cyc), .wbm_stb (wbm_stb), .wbm_we (wbm_we), .wbm_adr (wbm_adr),
    .wbm_dat_m2s (wbm_dat_m2s), .wbm_dat_s2m (wbm_dat_s2m), .wbm_ack (wbm_ack), .wbm_sel (wbm_sel),
    .usb_rst_req_i (usb_rst_req_i), .cnt_clr_i (cnt_clr_i), .busy_o (busy_o),
    .evt_valid_o (evt_valid_o), .evt_status_o (evt_status_o),
    .timeout_cnt_o (timeout_cnt_o), .received_cnt_o (received_cnt_o), .bad_cnt_o (bad_cnt_o)
  );

  // Slave: ack one cycle after stb, flags set by injection and cleared by any write.
  logic       sl_ack = 1'b0;
  logic [2:0] sl_st = 3'b000;
  logic       sl_to = 1'b0, sl_rc = 1'b0, sl_bad = 1'b0, sl_soft_rst = 1'b0;
  logic       inj_valid = 1'b0;
  logic [5:0] inj_flags = 6'd0;

  always @(posedge clk) begin
    sl_ack <= wbm_cyc & wbm_stb & ~sl_ack;
    if (inj_valid) begin
      sl_st  <= sl_st | inj_flags[5:3];
      sl_to  <= sl_to | inj_flags[2];
      sl_rc  <= sl_rc | inj_flags[1];
      sl_bad <= sl_bad | inj_flags[0];
    end
    if (wbm_cyc && wbm_stb && sl_ack && wbm_we) begin
      case (wbm_adr)
        32'd0:   sl_soft_rst <= wbm_dat_m2s[0];
        32'd4:   sl_st <= 3'b000;
        32'd8:   sl_to <= 1'b0;
        32'd12:  sl_rc <= 1'b0;
        32'd16:  sl_bad <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (wbm_adr)
      32'd4:   wbm_dat_s2m = {29'd0, sl_st};
      32'd8:   wbm_dat_s2m = {31'd0, sl_to};
      32'd12:  wbm_dat_s2m = {31'd0, sl_rc};
      32'd16:  wbm_dat_s2m = {31'd0, sl_bad};
      default: wbm_dat_s2m = 32'd0;
    endcase
  end
  assign wbm_ack = sl_ack;

  // Monitor on the falling edge: completed transactions, stb length, events, reset window.
  logic [64:0] log_q[$];
  logic [64:0] exp_q[$];
  int len_q[$];
  int cyc_q[$];
  int cyc_n = 0, stb_len = 0, evt_n = 0, rst_hi = 0, busy_bad = 0;

  always @(negedge clk) begin
    cyc_n = cyc_n + 1;
    if (rst_i) begin
      stb_len = 0;
    end else if (wbm_stb) begin
      stb_len = stb_len + 1;
      if (wbm_ack) begin
        log_q.push_back({wbm_we, wbm_adr, wbm_dat_m2s});
        len_q.push_back(stb_len);
        cyc_q.push_back(cyc_n);
        stb_len = 0;
      end
    end
    if (evt_valid_o) evt_n = evt_n + 1;
    if (sl_soft_rst) begin
      rst_hi = rst_hi + 1;
      if (!busy_o) busy_bad = busy_bad + 1;
    end
  end

  int checks = 0, passes = 0, fails = 0;
  int m_to = 0, m_rc = 0, m_bad = 0, m_evt = 0;
  logic [2:0] m_st = 3'b000;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] txn(input bit we, input int adr, input int dat);
    return {we, 32'(adr), 32'(dat)};
  endfunction

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic wait_log(input int n);
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (log_q.size() >= n) break;
    end
  endtask

  task automatic check_log(input int base, input string tag);
    chk("txn_count", 96'(log_q.size() - base), 96'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < log_q.size()) begin
        chk(tag, 96'(log_q[base+i]), 96'(exp_q[i]));
        chk("stb_len", 96'(len_q[base+i]), 96'd2);
      end
    end
  endtask

  task automatic check_counters();
    chk("timeout_cnt", 96'(timeout_cnt_o), 96'(m_to));
    chk("received_cnt", 96'(received_cnt_o), 96'(m_rc));
    chk("bad_cnt", 96'(bad_cnt_o), 96'(m_bad));
  endtask

  // One sweep with the given flags raised beforehand; optional counter clear during the addr 8 ack.
  task automatic sweep(input logic [2:0] st, input bit to, input bit rc, input bit bad, input bit clr8);
    int base;
    bit clr_done;
    base = log_q.size();
    clr_done = 1'b0;
    exp_q = {};
    exp_q.push_back(txn(1'b0, 4, 0));
    if (st != 3'b000) exp_q.push_back(txn(1'b1, 4, 0));
    exp_q.push_back(txn(1'b0, 8, 0));
    if (to) exp_q.push_back(txn(1'b1, 8, 0));
    exp_q.push_back(txn(1'b0, 12, 0));
    if (rc) exp_q.push_back(txn(1'b1, 12, 0));
    exp_q.push_back(txn(1'b0, 16, 0));
    if (bad) exp_q.push_back(txn(1'b1, 16, 0));
    inj_flags = {st, to, rc, bad};
    inj_valid = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      inj_valid = 1'b0;
      cnt_clr_i = 1'b0;
      if (clr8 && !clr_done && wbm_cyc && wbm_ack && !wbm_we && (wbm_adr == 32'd8)) begin
        cnt_clr_i = 1'b1;
        clr_done = 1'b1;
      end
      if (log_q.size() >= base + exp_q.size()) break;
    end
    @(negedge clk);
    cnt_clr_i = 1'b0;
    @(negedge clk);
    if (clr8) begin
      m_to = 0; m_rc = 0; m_bad = 0;
    end else begin
      m_to = sat(m_to + int'(to));
    end
    m_rc  = sat(m_rc + int'(rc));
    m_bad = sat(m_bad + int'(bad));
    if (st != 3'b000) begin
      m_evt++;
      m_st = st;
    end
    check_log(base, "sweep_txn");
    if (log_q.size() >= base + exp_q.size())
      chk("sweep_span", 96'(cyc_q[base+exp_q.size()-1] - cyc_q[base]), 96'(3 * (exp_q.size() - 1)));
    check_counters();
    chk("evt_count", 96'(evt_n), 96'(m_evt));
    chk("evt_status", 96'(evt_status_o), 96'(m_st));
    chk("busy_idle", 96'(busy_o), 96'd0);
  endtask

  initial begin
    int base;
    bit seen;
    repeat (3) @(negedge clk);
    chk("rst_cyc", 96'(wbm_cyc), 96'd0);
    chk("rst_stb", 96'(wbm_stb), 96'd0);
    chk("rst_we", 96'(wbm_we), 96'd0);
    chk("rst_adr", 96'(wbm_adr), 96'd0);
    chk("rst_dat", 96'(wbm_dat_m2s), 96'd0);
    chk("rst_busy", 96'(busy_o), 96'd0);
    chk("rst_evt", 96'({evt_valid_o, evt_status_o}), 96'd0);
    check_counters();

    // Soft reset sequence after release: write 1, hold, write 0, then the first sweep.
    rst_hi = 0;
    rst_i = 1'b0;
    wait_log(2);
    exp_q = {txn(1'b1, 0, 1), txn(1'b1, 0, 0)};
    check_log(0, "rst_seq");
    chk("rst_window", 96'(rst_hi), 96'(RH + 3));
    chk("busy_during_rst", 96'(busy_bad), 96'd0);
    sweep(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 5; i++) sweep(3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("timeout_5", 96'(timeout_cnt_o), 96'd5);

    sweep(3'b101, 1'b0, 1'b0, 1'b0, 1'b0);
    sweep(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) sweep(3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("received_sat", 96'(received_cnt_o), 96'(MAXC));

    sweep(3'b000, 1'b1, 1'b1, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++)
      sweep(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);

    // Reset request during the addr 8 read: that read completes, 12/16 are skipped.
    base = log_q.size();
    rst_hi = 0;
    busy_bad = 0;
    seen = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (wbm_stb && !wbm_ack && !wbm_we && (wbm_adr == 32'd8)) begin
        usb_rst_req_i = 1'b1;
        seen = 1'b1;
        break;
      end
    end
    @(negedge clk);
    usb_rst_req_i = 1'b0;
    chk("req_window_seen", 96'(seen), 96'd1);
    wait_log(base + 8);
    @(negedge clk);
    exp_q = {txn(1'b0, 4, 0), txn(1'b0, 8, 0), txn(1'b1, 0, 1), txn(1'b1, 0, 0),
             txn(1'b0, 4, 0), txn(1'b0, 8, 0), txn(1'b0, 12, 0), txn(1'b0, 16, 0)};
    check_log(base, "req_txn");
    chk("req_rst_window", 96'(rst_hi), 96'(RH + 3));
    chk("req_busy", 96'(busy_bad), 96'd0);
    check_counters();

    // Asynchronous reset while stb is high drops the bus in the same cycle.
    seen = 1'b0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (wbm_stb && !wbm_ack) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stb_seen", 96'(seen), 96'd1);
    rst_i = 1'b1;
    #1;
    chk("async_cyc", 96'(wbm_cyc), 96'd0);
    chk("async_stb", 96'(wbm_stb), 96'd0);
    m_to = 0; m_rc = 0; m_bad = 0; m_st = 3'b000;
    @(negedge clk);
    check_counters();
    chk("async_evt_status", 96'(evt_status_o), 96'd0);
    base = log_q.size();
    rst_hi = 0;
    rst_i = 1'b0;
    wait_log(base + 6);
    exp_q = {txn(1'b1, 0, 1), txn(1'b1, 0, 0), txn(1'b0, 4, 0), txn(1'b0, 8, 0),
             txn(1'b0, 12, 0), txn(1'b0, 16, 0)};
    check_log(base, "restart_txn");
    chk("restart_rst_window", 96'(rst_hi), 96'(RH + 3));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/usb_wb_status_poller.md
# usb_wb_status_poller

Wishbone master that owns the USB control/status register slave on behalf of hardware. On reset release and on request it sequences the USB soft reset (assert, hold, release); otherwise it periodically sweeps the four status registers, clears any set flags (write-to-clear), and converts them into event pulses and saturating counters for the rest of the design. It sits between the USB core's control/status register slave and system-level monitoring or interrupt logic.

## Interface
- POLL_INTERVAL, 1024: idle cycles between the end of one sweep and the start of the next; minimum 1.
- RST_HOLD, 16: cycles USB soft reset is held asserted; minimum 1.
- CNT_W, 16: width of each event counter.
- clk_i  in  1  clock.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high.
- wbm  wb_if.mst  -  master port to the control/status slave: cyc, stb, we, adr, dat_m2s, dat_s2m, ack; sel tied all-ones if present.
- usb_rst_req_i  in  1  single-cycle request for a USB soft reset sequence.
- cnt_clr_i  in  1  synchronous clear of all three counters.
- busy_o  out  1  high while a reset sequence is active.
- evt_valid_o  out  1  one-cycle pulse when a status-register read returns nonzero.
- evt_status_o  out  3  {rps_tx_err, get_max_lun, msd_reset} from that read; held until the next pulse.
- timeout_cnt_o, received_cnt_o, bad_cnt_o  out  CNT_W each  saturating counts of ACK timeout, ACK received and ACK bad-packet flags.

## Operation
- Register map, byte addresses with upper adr bits zero: 0 soft reset (bit0, write), 4 MSD status (bits 2:0, read / any write clears), 8 ACK timeout, 12 ACK received, 16 ACK bad packet (bit0, read / any write clears).
- FSM states: RST_ASSERT, RST_HOLD, RST_RELEASE, POLL_RD, POLL_CLR, WAIT.
- After rst_i deasserts, the FSM enters RST_ASSERT. RST_ASSERT writes 1 to addr 0. RST_HOLD counts RST_HOLD cycles. RST_RELEASE writes 0 to addr 0. The FSM then enters POLL_RD at addr 4. busy_o is high in all three RST states.
- POLL_RD reads the current address.
  - Nonzero data: go to POLL_CLR, which writes 0 to the same address. The action from the read fires in the ack cycle: addr 4 pulses evt_valid_o and loads evt_status_o; addr 8/12/16 increments its counter.
  - Zero data: skip the clear.
  - Then advance to the next address in the order 4, 8, 12, 16. After 16, go to WAIT for POLL_INTERVAL cycles, then return to POLL_RD at addr 4.
- usb_rst_req_i arriving outside the RST states:
  - Latched as pending.
  - Taken at the next transaction boundary (never mid-transaction).
  - Abandons the rest of the sweep and goes to RST_ASSERT.
- usb_rst_req_i in RST_HOLD restarts the hold count. In RST_ASSERT or RST_RELEASE it is ignored.
- Counters saturate at all-ones. cnt_clr_i wins over an increment in the same cycle.
- A flag set by the slave between the read and the clear write is lost. This is accepted; the clear write is issued only when the read was nonzero to minimise the window.

## Timing
- Reset values: cyc=stb=we=0, adr=0, dat_m2s=0, busy_o=0, evt_valid_o=0, evt_status_o=0, all counters 0.
- Wishbone bus cycle:
  - cyc, stb, we, adr and dat_m2s are registered and held stable until ack is sampled high.
  - The slave acks one cycle after stb, so stb is high for 2 cycles.
  - cyc and stb drop in the cycle after ack, and that cycle stays idle (cyc low). Every transaction therefore occupies 3 cycles.
- Read data is sampled from dat_s2m in the ack cycle. evt_valid_o and the counter increments take effect on the following edge.
- Sweep length: 12 cycles with no flags set, 24 cycles with all flags set.
- rst_i asserted mid-transaction drops cyc/stb immediately (asynchronous) and restarts from RST_ASSERT after release.

## Structure
- Package usb_ctrl_pkg holds:
  - address constants USB_REG_SOFT_RST=0, USB_REG_STATUS=4, USB_REG_ACK_TIMEOUT=8, USB_REG_ACK_RECEIVED=12, USB_REG_ACK_BAD=16;
  - the FSM state enum;
  - the packed MSD status struct {rps_tx_err, get_max_lun, msd_reset}.
- Sub-module usb_sat_counter (parameter W; ports clk_i, rst_i, clr_i, inc_i, cnt_o), instantiated three times.

## Test plan
- Reset release with RST_HOLD=4:
  - write 1 to addr 0, 4 hold cycles, write 0 to addr 0;
  - busy_o high throughout and low after;
  - first read at addr 4 follows.
- Slave status reads 3'b101:
  - evt_valid_o pulses once with evt_status_o=3'b101;
  - a write to addr 4 follows;
  - the next sweep reads 0 and issues no write.
- ACK timeout flag pulsed 5 times across 5 sweeps -> timeout_cnt_o=5.
- CNT_W=2 with 6 flags -> counter sticks at 3.
- cnt_clr_i in the same cycle as an increment -> counter 0.
- usb_rst_req_i asserted during the addr 8 read:
  - the addr 8 transaction completes;
  - addrs 12/16 are not accessed;
  - the reset sequence runs, then the sweep restarts at addr 4.
- rst_i asserted while stb is high -> cyc/stb low within the same cycle; the sequence restarts from RST_ASSERT after release.
